// File: rtl/cci_mpf_prim_pkg.sv
// Shared types for the LUTRAM primitive helpers.
// Holds the stream-read engine state encoding and its buffer sizing rule.
package cci_mpf_prim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } t_lutram_stream_rd_state;

  // Enough slots for every read that can be in the memory pipe plus one
  // beat waiting at the consumer and one arriving behind it.
  function automatic int lutram_stream_rd_buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_lutram_stream_rd_buf.sv
// Register FIFO of {last, data} beats for the stream-read engine; zero-latency head.
// Push/pop in the same cycle are allowed; the caller's credit scheme keeps it from overflowing.
module cci_mpf_prim_lutram_stream_rd_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign head   = store[rd_ptr];
  assign do_pop = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: rtl/cci_mpf_prim_lutram_stream_rd.sv
// Streams LUTRAM entries base..base+len-1 (wrapping) out as a valid/ready beat stream with last.
// Latency: first beat 2+RD_LATENCY cycles after accept; option CCI_MPF_PRIM_LUTRAM_STREAM_RD_CLEAR_EN clears entries as read.
// Backpressure: reads issue only against buffer credit, so a stalled consumer never loses data.
module cci_mpf_prim_lutram_stream_rd
  import cci_mpf_prim_pkg::*;
#(
  parameter int N_ENTRIES = 32,
  parameter int N_DATA_BITS = 64,
  parameter int RD_LATENCY = 0,
  parameter logic [N_DATA_BITS-1:0] CLEAR_VALUE = N_DATA_BITS'(0)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_rdy,
  input  logic [$clog2(N_ENTRIES)-1:0] cmd_base,
  input  logic [$clog2(N_ENTRIES):0]   cmd_len,
  output logic [$clog2(N_ENTRIES)-1:0] mem_raddr,
  input  logic [N_DATA_BITS-1:0]       mem_rdata,
  output logic [$clog2(N_ENTRIES)-1:0] mem_waddr,
  output logic                         mem_wen,
  output logic [N_DATA_BITS-1:0]       mem_wdata,
  output logic                         out_valid,
  output logic [N_DATA_BITS-1:0]       out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         busy
);
  localparam int AW        = $clog2(N_ENTRIES);
  localparam int LW        = AW + 1;
  localparam int BUF_DEPTH = lutram_stream_rd_buf_depth(RD_LATENCY);
  localparam int CW        = $clog2(BUF_DEPTH + 1);

  typedef logic [AW-1:0]          t_addr;
  typedef logic [N_DATA_BITS-1:0] t_data;
  typedef struct packed {
    logic  last;
    t_data data;
  } t_beat;

  t_lutram_stream_rd_state state;
  t_addr                   rd_addr;
  logic [LW-1:0]           remaining;

  logic          issue;
  logic          issue_last;
  logic          push;
  logic          push_last;
  logic          pop;
  logic          drain_done;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] in_flight;
  logic [CW:0]   credit_used;
  logic          buf_empty;
  t_beat         head;

  assign credit_used = {1'b0, buf_count} + {1'b0, in_flight};
  assign issue       = (state == ISSUE) && (credit_used < (CW + 1)'(BUF_DEPTH));
  assign issue_last  = issue && (remaining == LW'(1));
  assign pop         = out_valid && out_ready;

  // Done once nothing is in the memory pipe and the final beat leaves this cycle.
  assign drain_done = (in_flight == '0) && !push &&
                      ((buf_count == '0) || ((buf_count == CW'(1)) && pop));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rd_addr   <= cmd_base;
            remaining <= cmd_len;
            if (cmd_len != '0) state <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            rd_addr   <= rd_addr + t_addr'(1);
            remaining <= remaining - LW'(1);
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_comb_rd
      assign push      = issue;
      assign push_last = issue_last;
      assign in_flight = '0;
    end else begin : g_pipe_rd
      logic [RD_LATENCY-1:0] sr_vld;
      logic [RD_LATENCY-1:0] sr_last;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sr_vld  <= '0;
          sr_last <= '0;
        end else begin
          sr_vld[0]  <= issue;
          sr_last[0] <= issue_last;
          for (int i = 1; i < RD_LATENCY; i++) begin
            sr_vld[i]  <= sr_vld[i-1];
            sr_last[i] <= sr_last[i-1];
          end
        end
      end

      assign push      = sr_vld[RD_LATENCY-1];
      assign push_last = sr_last[RD_LATENCY-1];
      assign in_flight = CW'($countones(sr_vld));
    end
  endgenerate

  cci_mpf_prim_lutram_stream_rd_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(t_beat))
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_last, mem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  assign out_valid = !buf_empty;
  assign out_data  = head.data;
  assign out_last  = head.last;
  assign mem_raddr = rd_addr;
  assign cmd_rdy   = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef CCI_MPF_PRIM_LUTRAM_STREAM_RD_CLEAR_EN
  assign mem_wen = issue;
`else
  assign mem_wen = 1'b0;
`endif
  // Write address/data are zero whenever no write is being made.
  assign mem_waddr = mem_wen ? rd_addr : '0;
  assign mem_wdata = CLEAR_VALUE & {N_DATA_BITS{mem_wen}};

  a_cmd_len: assert property (@(posedge clk) disable iff (!reset)
                              (cmd_valid && cmd_rdy) |-> (cmd_len <= LW'(N_ENTRIES)));

endmodule

// File: doc/cci_mpf_prim_lutram_stream_rd.md
# cci_mpf_prim_lutram_stream_rd

Streaming read engine for the LUTRAM primitives: accepts a (base, length) command, walks consecutive LUTRAM addresses with wrap-around, and returns the entries as a valid/ready data stream with a last flag. It drives the read port (and, optionally, the write port) of an external LUTRAM instance of either read latency, absorbing in-flight reads in a credit-managed output buffer so backpressure never drops data. It is the consumer-side counterpart to producers that fill LUTRAM tables (e.g. drain of a staging table to a CCI channel).

## Interface
- N_ENTRIES, 32: LUTRAM depth; power of 2.
- N_DATA_BITS, 64: entry width.
- RD_LATENCY, 0: attached memory read latency in cycles. Use 0 for plain LUTRAM and 1 for the multi-chunk (T1_rdata) variant; only 0 and 1 are legal.
- CLEAR_VALUE, N_DATA_BITS'(0): value written back by the clear-on-read feature.

Ports:
- clk, in, 1: clock. One clock; reset is asynchronous and active-low.
- reset, in, 1: asynchronous, active-low reset.
- cmd_valid, in, 1: command offered.
- cmd_rdy, out, 1: engine idle and able to accept a command.
- cmd_base, in, $clog2(N_ENTRIES): first address.
- cmd_len, in, $clog2(N_ENTRIES)+1: entry count, 0..N_ENTRIES.
- mem_raddr, out, $clog2(N_ENTRIES): LUTRAM read address.
- mem_rdata, in, N_DATA_BITS: LUTRAM read data, RD_LATENCY cycles after mem_raddr.
- mem_waddr, out, $clog2(N_ENTRIES): LUTRAM write address (clear-on-read).
- mem_wen, out, 1: LUTRAM write enable.
- mem_wdata, out, N_DATA_BITS: LUTRAM write data.
- out_valid, out, 1: stream beat valid.
- out_data, out, N_DATA_BITS: stream data.
- out_last, out, 1: final beat of the command.
- out_ready, in, 1: consumer accepts the beat.
- busy, out, 1: a command is in progress (state not IDLE).

## Operation
- States:
  - IDLE: cmd_rdy=1. On cmd_valid, latch base into rd_addr and len into remaining. If len==0, stay in IDLE and emit no beats. Otherwise go to ISSUE.
  - ISSUE: issue one read per cycle while credit allows. Credit condition: buf_count + in_flight < BUF_DEPTH, where BUF_DEPTH = RD_LATENCY + 2.
    - Each issue: rd_addr <= rd_addr + 1, wrapping modulo N_ENTRIES; remaining <= remaining - 1. The last issue is tagged last.
    - After the last issue, go to DRAIN.
  - DRAIN: return to IDLE when in_flight==0 and the buffer is empty, i.e. after the last beat handshakes.
- mem_raddr = rd_addr at all times; only credited issue cycles are tracked.
- Returning data and its last tag are pushed into the buffer. Beat transfer occurs on out_valid && out_ready, in FIFO order.
- The buffer never overflows; pushing into a full buffer is an assertion error.
- cmd_len > N_ENTRIES: behaviour undefined; assertion fires.
- Commands are not accepted outside IDLE. cmd_valid while busy is held off by cmd_rdy=0.

## Timing
- Reset values: state IDLE, cmd_rdy=1, busy=0, out_valid=0, out_last=0, out_data=0, mem_raddr=0, mem_wen=0, mem_waddr=0, mem_wdata=0, buffer empty, in_flight=0.
- Command accepted at edge n:
  - first read address is driven in cycle n+1;
  - first out_valid is in cycle n+2+RD_LATENCY.
- With out_ready held high, throughput is one beat per cycle. A len=L command has its last beat in cycle n+1+RD_LATENCY+L, and cmd_rdy reasserts the following cycle.
- out_ready low: issue stalls once credits are exhausted. out_data, out_valid and out_last are held stable until accepted.
- Wrap-around: base=N_ENTRIES-1 with len=2 reads addresses N_ENTRIES-1 then 0.
- Asynchronous reset mid-command: returns immediately to reset values. In-flight reads are discarded and no further beats appear.

## Configuration
- CCI_MPF_PRIM_LUTRAM_STREAM_RD_CLEAR_EN:
  - Defined: every issued read also asserts mem_wen with mem_waddr=rd_addr and mem_wdata=CLEAR_VALUE in the same cycle. The attached LUTRAM must be built with READ_DURING_WRITE="OLD_DATA", so the returned data is the pre-clear value.
  - Undefined: mem_wen is constant 0, and mem_waddr and mem_wdata are constant 0.

## Structure
- Package cci_mpf_prim_pkg holds the state enum t_lutram_stream_rd_state (IDLE, ISSUE, DRAIN).
- Address and data typedefs are local, because they depend on parameters.
- Sub-module cci_mpf_prim_lutram_stream_rd_buf: register FIFO of depth BUF_DEPTH holding {last, data}, with count output. It is the natural split.
- In-flight tracking is a RD_LATENCY-deep valid/last shift register in the top level.

## Test plan
- RD_LATENCY=0, memory preloaded with entry[i]=i, cmd base=4 len=8, out_ready=1 -> beats 4..11 in consecutive cycles, first valid 2 cycles after accept, out_last only on 11.
- RD_LATENCY=1, base=30 len=4 (N_ENTRIES=32) -> beats 30, 31, 0, 1, with out_last on 1 and the wrap correct.
- out_ready toggling 1,0,0,1 repeating, len=16, both latencies -> all 16 values in order, no loss or duplication, buffer never exceeds BUF_DEPTH.
- cmd_len=0 -> no out_valid, cmd_rdy stays 1, busy stays 0.
- Reset asserted 3 cycles into a len=20 command -> all outputs at reset values immediately. A new len=2 command afterwards returns exactly 2 beats.
- CLEAR_EN defined, entry[i]=i+100, base=0 len=4 -> beats 100..103, then a second identical command returns 0,0,0,0.
